// File: rtl/arb_mux_stream_if.sv
// Stream bundle between N producers, the arbitrating mux and one consumer.
interface arb_mux_stream_if #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned SEL_WIDTH = 2
);
  localparam int unsigned N = 1 << SEL_WIDTH;

  logic [WIDTH*N-1:0]   in_data_flat;
  logic [N-1:0]         in_valid;
  logic [N-1:0]         in_last;
  logic [N-1:0]         in_ready;
  logic [WIDTH-1:0]     out_data;
  logic                 out_valid;
  logic                 out_last;
  logic [SEL_WIDTH-1:0] out_sel;
  logic                 out_ready;

  // Producer/consumer side of the bundle.
  modport master (
    output in_data_flat, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_last, out_sel
  );

  // Mux side of the bundle.
  modport slave (
    input  in_data_flat, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_last, out_sel
  );
endinterface

// File: rtl/arb_mux_stream.sv
// N-channel packet-aware arbitrating stream mux with a registered output stage.
// A packet, once started, owns the output until its last beat is transferred.
module arb_mux_stream #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned SEL_WIDTH = 2,
  parameter int unsigned MODE      = 0   // 0 = round-robin, 1 = fixed priority
) (
  input logic           clk,
  input logic           rst_n,
  arb_mux_stream_if.slave bus
);
  localparam int unsigned N = 1 << SEL_WIDTH;

  localparam logic [0:0] ST_OPEN   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [SEL_WIDTH-1:0] lock_ch_q, lock_ch_d;
  logic [SEL_WIDTH-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 last_q, last_d;
  logic [SEL_WIDTH-1:0] sel_q, sel_d;

  logic                 load_c;
  logic                 gnt_any_c;
  logic [SEL_WIDTH-1:0] gnt_idx_c;
  logic [SEL_WIDTH-1:0] cand_c;
  logic [N-1:0]         gnt_c;
  logic [WIDTH-1:0]     gnt_data_c;
  logic                 gnt_last_c;
  logic                 xfer_c;

  // Output register may accept a new beat when empty or being drained.
  assign load_c = !valid_q || bus.out_ready;

  // Arbiter: locked channel wins outright, otherwise search by policy.
  always_comb begin
    gnt_any_c = 1'b0;
    gnt_idx_c = '0;
    cand_c    = '0;
    if (state_q == ST_LOCKED) begin
      gnt_any_c = 1'b1;
      gnt_idx_c = lock_ch_q;
    end else begin
      for (int unsigned k = 0; k < N; k++) begin
        if (MODE == 0) begin
          cand_c = ptr_q + SEL_WIDTH'(k);
        end else begin
          cand_c = SEL_WIDTH'(k);
        end
        if (!gnt_any_c && bus.in_valid[cand_c]) begin
          gnt_any_c = 1'b1;
          gnt_idx_c = cand_c;
        end
      end
    end
  end

  // One-hot grant vector.
  assign gnt_c = gnt_any_c ? (N'(1) << gnt_idx_c) : '0;

  // Payload of the granted channel.
  always_comb begin
    gnt_data_c = '0;
    gnt_last_c = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (SEL_WIDTH'(i) == gnt_idx_c) begin
        gnt_data_c = bus.in_data_flat[WIDTH*i +: WIDTH];
        gnt_last_c = bus.in_last[i];
      end
    end
  end

  // Ready is held low while reset is asserted so nothing is accepted.
  assign bus.in_ready = (rst_n && load_c) ? gnt_c : '0;

  assign xfer_c = load_c && gnt_any_c && bus.in_valid[gnt_idx_c];

  // Next-state: output stage, packet lock and round-robin pointer.
  always_comb begin
    state_d   = state_q;
    lock_ch_d = lock_ch_q;
    ptr_d     = ptr_q;
    data_d    = data_q;
    valid_d   = valid_q;
    last_d    = last_q;
    sel_d     = sel_q;
    if (load_c) begin
      valid_d = xfer_c;
      if (xfer_c) begin
        data_d = gnt_data_c;
        last_d = gnt_last_c;
        sel_d  = gnt_idx_c;
        if (gnt_last_c) begin
          state_d = ST_OPEN;
          if (MODE == 0) begin
            ptr_d = gnt_idx_c + SEL_WIDTH'(1);
          end
        end else begin
          state_d   = ST_LOCKED;
          lock_ch_d = gnt_idx_c;
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_OPEN;
      lock_ch_q <= '0;
      ptr_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      sel_q     <= '0;
    end else begin
      state_q   <= state_d;
      lock_ch_q <= lock_ch_d;
      ptr_q     <= ptr_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      sel_q     <= sel_d;
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.out_last  = last_q;
  assign bus.out_sel   = sel_q;

endmodule

// File: tb/tb_arb_mux_stream.sv
// Bench for arb_mux_stream: one round-robin and one fixed-priority instance,
// both tracked every cycle by a transaction-level reference model.
module tb_arb_mux_stream;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Stimulus per instance (0 = round-robin, 1 = fixed priority).
  logic       iv   [2][N];
  logic       il   [2][N];
  logic [7:0] idat [2][N];
  logic       ordy [2];

  // Reference model state.
  logic       mv  [2];
  logic [7:0] md  [2];
  logic       ml  [2];
  logic [1:0] ms  [2];
  logic       lk  [2];
  int         lch [2];
  int         ptr [2];
  int         mg  [2];
  logic       mload [2];
  logic [3:0] mrdy  [2];

  int n_tests = 0;
  int n_fail  = 0;

  arb_mux_stream_if #(.WIDTH(8), .SEL_WIDTH(2)) bus_rr ();
  arb_mux_stream_if #(.WIDTH(8), .SEL_WIDTH(2)) bus_fp ();

  arb_mux_stream #(.WIDTH(8), .SEL_WIDTH(2), .MODE(0)) u_rr (
    .clk(clk), .rst_n(rst_n), .bus(bus_rr)
  );
  arb_mux_stream #(.WIDTH(8), .SEL_WIDTH(2), .MODE(1)) u_fp (
    .clk(clk), .rst_n(rst_n), .bus(bus_fp)
  );

  always_comb begin
    for (int c = 0; c < N; c++) begin
      bus_rr.in_valid[c]            = iv[0][c];
      bus_rr.in_last[c]             = il[0][c];
      bus_rr.in_data_flat[8*c +: 8] = idat[0][c];
      bus_fp.in_valid[c]            = iv[1][c];
      bus_fp.in_last[c]             = il[1][c];
      bus_fp.in_data_flat[8*c +: 8] = idat[1][c];
    end
    bus_rr.out_ready = ordy[0];
    bus_fp.out_ready = ordy[1];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // f: 0 in_ready, 1 out_valid, 2 out_data, 3 out_last, 4 out_sel
  function automatic logic [31:0] dut(input int d, input int f);
    if (d == 0) begin
      case (f)
        0: return 32'(bus_rr.in_ready);
        1: return 32'(bus_rr.out_valid);
        2: return 32'(bus_rr.out_data);
        3: return 32'(bus_rr.out_last);
        default: return 32'(bus_rr.out_sel);
      endcase
    end else begin
      case (f)
        0: return 32'(bus_fp.in_ready);
        1: return 32'(bus_fp.out_valid);
        2: return 32'(bus_fp.out_data);
        3: return 32'(bus_fp.out_last);
        default: return 32'(bus_fp.out_sel);
      endcase
    end
  endfunction

  function automatic void mreset(input int d);
    mv[d] = 1'b0; md[d] = 8'h00; ml[d] = 1'b0; ms[d] = 2'd0;
    lk[d] = 1'b0; lch[d] = 0; ptr[d] = 0;
  endfunction

  // Channel the rules select this cycle, or -1 when nobody is eligible.
  function automatic int pick(input int d);
    int c;
    if (lk[d]) return lch[d];
    for (int k = 0; k < N; k++) begin
      c = (d == 0) ? (ptr[d] + k) % N : k;
      if (iv[d][c]) return c;
    end
    return -1;
  endfunction

  // One clock: check ready before the edge, advance model, check outputs after.
  task automatic cycle();
    #1;
    for (int d = 0; d < 2; d++) begin
      mload[d] = !mv[d] || ordy[d];
      mg[d]    = pick(d);
      mrdy[d]  = (rst_n && mload[d] && mg[d] >= 0) ? 4'(1 << mg[d]) : 4'b0000;
      chk(d == 0 ? "rr_in_ready" : "fp_in_ready", dut(d, 0), 32'(mrdy[d]));
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        mreset(d);
      end else if (mload[d]) begin
        if (mg[d] >= 0 && iv[d][mg[d]]) begin
          mv[d] = 1'b1;
          md[d] = idat[d][mg[d]];
          ml[d] = il[d][mg[d]];
          ms[d] = 2'(mg[d]);
          if (il[d][mg[d]]) begin
            lk[d] = 1'b0;
            if (d == 0) ptr[d] = (mg[d] + 1) % N;
          end else begin
            lk[d]  = 1'b1;
            lch[d] = mg[d];
          end
        end else begin
          mv[d] = 1'b0;
        end
      end
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      chk(d == 0 ? "rr_out_valid" : "fp_out_valid", dut(d, 1), 32'(mv[d]));
      chk(d == 0 ? "rr_out_data"  : "fp_out_data",  dut(d, 2), 32'(md[d]));
      chk(d == 0 ? "rr_out_last"  : "fp_out_last",  dut(d, 3), 32'(ml[d]));
      chk(d == 0 ? "rr_out_sel"   : "fp_out_sel",   dut(d, 4), 32'(ms[d]));
    end
    @(negedge clk);
  endtask

  task automatic idle_all(input int d);
    for (int c = 0; c < N; c++) begin
      iv[d][c] = 1'b0; il[d][c] = 1'b0; idat[d][c] = 8'h00;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    mreset(0); mreset(1);
    for (int d = 0; d < 2; d++) begin
      ordy[d] = 1'b1;
      for (int c = 0; c < N; c++) begin
        iv[d][c] = 1'b1; il[d][c] = 1'b1; idat[d][c] = 8'(8'h10 + c);
      end
    end
    @(negedge clk);

    // Reset with every channel requesting.
    cycle(); cycle();
    chk("rst_out_valid", dut(0, 1), 0);
    chk("rst_in_ready",  dut(0, 0), 0);
    chk("rst_out_sel",   dut(0, 4), 0);
    rst_n = 1'b1;
    #1 chk("rel_first_grant", dut(0, 0), 32'h1);
    cycle();
    chk("rel_out_sel",  dut(0, 4), 0);
    chk("rel_out_data", dut(0, 2), 32'h10);

    // Single-beat packets rotate one channel per cycle.
    for (int i = 1; i <= 4; i++) begin
      cycle();
      chk("rot_valid", dut(0, 1), 1);
      chk("rot_data",  dut(0, 2), 32'(8'h10 + (i % 4)));
      chk("rot_sel",   dut(0, 4), 32'(i % 4));
    end

    // Packet lock holds across a producer gap.
    idle_all(0); idle_all(1);
    cycle();
    iv[0][1] = 1'b1; idat[0][1] = 8'hA0; il[0][1] = 1'b0;
    iv[0][2] = 1'b1; idat[0][2] = 8'hC2; il[0][2] = 1'b1;
    cycle();
    chk("lock_a0", dut(0, 2), 32'hA0);
    idat[0][1] = 8'hA1;
    cycle();
    chk("lock_a1", dut(0, 2), 32'hA1);
    iv[0][1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1 chk("lock_gap_rdy2", 32'(dut(0, 0) >> 2) & 32'h1, 0);
      cycle();
      chk("lock_gap_valid", dut(0, 1), 0);
    end
    iv[0][1] = 1'b1; idat[0][1] = 8'hA2; il[0][1] = 1'b1;
    cycle();
    chk("lock_a2",      dut(0, 2), 32'hA2);
    chk("lock_a2_last", dut(0, 3), 1);
    iv[0][1] = 1'b0;
    cycle();
    chk("lock_next_sel",  dut(0, 4), 2);
    chk("lock_next_data", dut(0, 2), 32'hC2);

    // Backpressure with a beat pending.
    ordy[0] = 1'b0;
    iv[0][3] = 1'b1; idat[0][3] = 8'hD3; il[0][3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("bp_in_ready", dut(0, 0), 0);
      cycle();
      chk("bp_valid", dut(0, 1), 1);
      chk("bp_data",  dut(0, 2), 32'hC2);
    end
    ordy[0] = 1'b1;
    #1 chk("bp_release_rdy", dut(0, 0), 32'h8);
    cycle();
    chk("bp_release_data", dut(0, 2), 32'hD3);
    chk("bp_release_sel",  dut(0, 4), 3);
    iv[0][3] = 1'b0;
    cycle();
    chk("bp_after_sel", dut(0, 4), 2);

    // Fixed priority starves the higher index.
    idle_all(0);
    iv[1][1] = 1'b1; idat[1][1] = 8'h11; il[1][1] = 1'b1;
    iv[1][3] = 1'b1; idat[1][3] = 8'h31; il[1][3] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1 chk("fp_rdy3", 32'(dut(1, 0) >> 3) & 32'h1, 0);
      cycle();
      chk("fp_sel",  dut(1, 4), 1);
      chk("fp_data", dut(1, 2), 32'h11);
    end

    // Reset in the middle of a packet on channel 2.
    idle_all(1);
    iv[0][2] = 1'b1; idat[0][2] = 8'hE0; il[0][2] = 1'b0;
    cycle();
    chk("midrst_pre", dut(0, 2), 32'hE0);
    rst_n = 1'b0;
    mreset(0); mreset(1);
    #1;
    chk("midrst_valid", dut(0, 1), 0);
    chk("midrst_data",  dut(0, 2), 0);
    chk("midrst_last",  dut(0, 3), 0);
    chk("midrst_sel",   dut(0, 4), 0);
    idat[0][2] = 8'hE1;
    iv[0][0] = 1'b1; idat[0][0] = 8'h55; il[0][0] = 1'b1;
    @(negedge clk);
    cycle();
    rst_n = 1'b1;
    #1 chk("midrst_grant0", dut(0, 0), 32'h1);
    cycle();
    chk("midrst_data0", dut(0, 2), 32'h55);
    chk("midrst_sel0",  dut(0, 4), 0);

    // Randomised traffic on both instances, protocol-compliant producers.
    idle_all(0); idle_all(1);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int d = 0; d < 2; d++) begin
        for (int c = 0; c < N; c++) begin
          if (!iv[d][c] || mrdy[d][c]) begin
            iv[d][c]   = ($urandom % 4) != 0;
            idat[d][c] = 8'($urandom);
            il[d][c]   = ($urandom % 3) == 0;
          end
        end
        ordy[d] = ($urandom % 4) != 0;
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/arb_mux_stream.md
Name: arb_mux_stream

Overview:
- N-channel streaming multiplexer, N = 1<<SEL_WIDTH, with valid/ready handshakes, packet-aware arbitration and a registered output stage.
- Sits between parallel producers (per-neuron accumulators, weight/activation fetch lanes) and a single shared consumer (activation unit, output buffer).
- Generalises the combinational select mux: the select is produced internally by an arbiter, packets are never interleaved, and backpressure is honoured.

Parameters:
- WIDTH, 8, data bits per channel.
- SEL_WIDTH, 2, channel index width; N = 1<<SEL_WIDTH channels.
- MODE, 0, arbitration policy: 0 = round-robin, 1 = fixed priority (lowest index wins).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data_flat  input  WIDTH*N  channel i data at [WIDTH*i +: WIDTH].
- in_valid  input  N  per-channel beat valid.
- in_last  input  N  per-channel end-of-packet marker, qualified by in_valid.
- in_ready  output  N  per-channel accept; combinational.
- out_data  output  WIDTH  registered data.
- out_valid  output  1  registered valid.
- out_last  output  1  registered end-of-packet.
- out_sel  output  SEL_WIDTH  index of the channel that sourced the current output beat.
- out_ready  input  1  consumer accept.

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_data=0, out_last=0, out_sel=0.
  - Lock cleared; round-robin pointer = 0.
- Load enable: load = !out_valid || out_ready.
- Grant (combinational, one-hot or zero):
  - When unlocked: MODE 0 picks the first valid channel searching from the pointer upward, modulo N. MODE 1 picks the lowest-index valid channel.
  - When locked: grant = locked channel only, regardless of other valids.
- in_ready[i] = load && grant[i]. All in_ready are 0 when no channel is granted.
- Transfer on channel g occurs when in_valid[g] && in_ready[g]. On the next edge:
  - out_data <= data of channel g, out_last <= in_last[g], out_sel <= g, out_valid <= 1.
- If load=1 and no transfer occurs, out_valid <= 0. The out_data, out_last and out_sel values are don't-care, but must hold their last values.
- If load=0, all output registers hold (stall).
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 beat/cycle sustained while out_ready=1.
- Lock rules:
  - A transfer with in_last=0 sets lock to g.
  - A transfer with in_last=1 clears lock.
  - While locked, an idle locked channel (in_valid=0) stalls the arbiter; no other channel is served.
- Round-robin pointer (MODE 0): on a transfer with in_last=1 from g, pointer <= (g+1) mod N, wrapping from N-1 to 0. It is unchanged otherwise.
- In MODE 1 the pointer is unused and held at 0.
- Single-beat packets (in_last=1 on every beat) rotate grant every beat in MODE 0.
- Simultaneous out_ready with a new transfer: the old beat is consumed and the new one loaded in the same edge, with no bubble.
- Reset mid-packet: the held output beat is discarded and the lock is released. Upstream is responsible for re-issuing packets.
- Protocol requirements:
  - Producers must not drop in_valid, or change data or last, while valid and not ready.
  - The block guarantees out_valid and out_data are stable while out_valid && !out_ready.
- N=2 (SEL_WIDTH=1) is the minimum supported configuration and must synthesise.

Test Plan:
- Reset with all in_valid=1 -> out_valid=0, in_ready=0 during reset; after release, first grant is channel 0 and out_sel=0 one cycle later.
- MODE 0, N=4, all channels valid with single-beat packets (last=1), data = 0x10+i, out_ready=1 -> out_data sequence 0x10,0x11,0x12,0x13,0x10; one beat per cycle; out_sel 0,1,2,3,0.
- MODE 0, channel 1 sends a 3-beat packet (0xA0,0xA1,0xA2, last on the third) while channel 2 is always valid; channel 1 drops valid for 2 cycles mid-packet -> no channel-2 beats appear before 0xA2; channel 2 is served next.
- MODE 1, channels 3 and 1 valid continuously with single-beat packets -> only channel 1 is ever granted; in_ready[3] stays 0.
- Backpressure: hold out_ready=0 for 4 cycles with a beat pending -> out_data and out_valid are stable, all in_ready=0; on release, the next beat follows with no gap.
- Assert rst_n low mid-packet on channel 2 -> outputs return to reset values immediately; after release, channel 0 can be granted (lock cleared, pointer=0).
